// File: rtl/servo_pwm_gen_pkg.sv
// Shared servo output-stage constants and the duty clamp used by the PID stage.
// Defaults: 20 ms frame, 1..2 ms pulse, 1.5 ms centre at 50 MHz.
package servo_pkg;

    localparam int DUTY_W      = 18;
    localparam int CNT_W       = 20;
    localparam int PERIOD_CNT  = 1_000_000;
    localparam int MIN_DUTY    = 50_000;
    localparam int CENTER_DUTY = 75_000;
    localparam int MAX_DUTY    = 100_000;

    typedef logic [DUTY_W-1:0] duty_t;

    function automatic duty_t clamp_duty(input duty_t x);
        if (x < duty_t'(MIN_DUTY)) begin
            return duty_t'(MIN_DUTY);
        end else if (x > duty_t'(MAX_DUTY)) begin
            return duty_t'(MAX_DUTY);
        end
        return x;
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo PWM output stage: frame counter, frame-boundary shadow registers for duty/enable,
// and a registered pulse output that is cycle-aligned with the frame counter.
module servo_pwm_gen #(
    parameter int PERIOD_CNT  = servo_pkg::PERIOD_CNT,
    parameter int MIN_DUTY    = servo_pkg::MIN_DUTY,
    parameter int CENTER_DUTY = servo_pkg::CENTER_DUTY,
    parameter int MAX_DUTY    = servo_pkg::MAX_DUTY,
    parameter int DUTY_W      = servo_pkg::DUTY_W,
    parameter int CNT_W       = servo_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              pwm_out,
    output logic              frame_tick,
    output logic [DUTY_W-1:0] duty_active
);

    // The counter is at least as wide as the duty word, since PERIOD_CNT > MAX_DUTY.
    localparam int PAD_W = CNT_W - DUTY_W;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic              en_act;
    logic              en_nxt;
    logic              boundary;
    logic              pwm_nxt;

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] x);
        if (x < DUTY_W'(MIN_DUTY)) begin
            return DUTY_W'(MIN_DUTY);
        end else if (x > DUTY_W'(MAX_DUTY)) begin
            return DUTY_W'(MAX_DUTY);
        end
        return x;
    endfunction

    // Next-state values; the pulse flop is driven from these so pwm_out lines up with cnt.
    always_comb begin
        boundary = (cnt == CNT_W'(PERIOD_CNT - 1));
        cnt_nxt  = boundary ? '0 : cnt + CNT_W'(1);
        duty_nxt = boundary ? sat_duty(duty_in) : duty_active;
        en_nxt   = boundary ? en : en_act;
        pwm_nxt  = en_nxt && (cnt_nxt < {{PAD_W{1'b0}}, duty_nxt});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            duty_active <= DUTY_W'(CENTER_DUTY);
            en_act      <= 1'b0;
            pwm_out     <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            duty_active <= duty_nxt;
            en_act      <= en_nxt;
            pwm_out     <= pwm_nxt;
            frame_tick  <= boundary;
        end
    end

endmodule
